// File: rtl/module_ula_74181_seq16_pkg.sv
// Shared constants and types for the nibble-serial 16-bit 74181 ALU.
//   WIDTH   : operand / result width in bits
//   NIBBLES : number of 4-bit slices processed per operation
//   state_t : control FSM states
package pkg_ula_74181;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/module_ula_74181_seq16_if.sv
// Request/response bundle of the nibble-serial 16-bit ALU.
//   master : producer/consumer side (drives request, out_ready)
//   slave  : ALU side (drives in_ready, result, flags, out_valid)
interface module_ula_74181_seq16_if;
    import pkg_ula_74181::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             c_in;
    logic [WIDTH-1:0] f;
    logic             c_out;
    logic             a_eq_b;
    logic             zero;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_valid, a, b, s, m, c_in, out_ready,
        input  in_ready, f, c_out, a_eq_b, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, s, m, c_in, out_ready,
        output in_ready, f, c_out, a_eq_b, zero, out_valid
    );

endinterface

// File: rtl/module_ula_74181_seq16_ula.sv
// Combinational 4-bit 74181-style slice with active-high data and carries.
// Ports: a, b (nibble operands), s (function select), m (1 = logic),
//        c_in (carry in, 1 adds one), f (result), c_out (carry out),
//        a_eq_b (nibble operands equal).
module module_ula_74181 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [3:0] f,
    output logic       c_out,
    output logic       a_eq_b
);

    logic [3:0] term_p;
    logic [3:0] term_g;
    logic [4:0] sum;
    logic [3:0] logic_f;

    // Every arithmetic function of the part is (A | B.S0 | ~B.S1) plus
    // (A.~B.S2 | A.B.S3) plus carry, so one adder covers all sixteen.
    always_comb begin
        term_p = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        term_g = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
        sum    = {1'b0, term_p} + {1'b0, term_g} + {4'b0000, c_in};
    end

    always_comb begin
        logic_f = 4'h0;
        case (s)
            4'b0000: logic_f = ~a;
            4'b0001: logic_f = ~(a | b);
            4'b0010: logic_f = ~a & b;
            4'b0011: logic_f = 4'h0;
            4'b0100: logic_f = ~(a & b);
            4'b0101: logic_f = ~b;
            4'b0110: logic_f = a ^ b;
            4'b0111: logic_f = a & ~b;
            4'b1000: logic_f = ~a | b;
            4'b1001: logic_f = ~(a ^ b);
            4'b1010: logic_f = b;
            4'b1011: logic_f = a & b;
            4'b1100: logic_f = 4'hF;
            4'b1101: logic_f = a | ~b;
            4'b1110: logic_f = a | b;
            default: logic_f = a;
        endcase
    end

    // Logic mode breaks the carry chain, so c_out is 0 there.
    assign f      = m ? logic_f : sum[3:0];
    assign c_out  = m ? 1'b0 : sum[4];
    assign a_eq_b = (a == b);

endmodule

// File: rtl/module_ula_74181_seq16.sv
// 16-bit 74181-style ALU built from one 4-bit slice reused over four cycles.
// Ports: clk, rst (synchronous, active-high), bus (slave side of the
//        request/response interface: in_valid/in_ready capture an operation,
//        out_valid/out_ready hand back f, c_out, a_eq_b, zero).
module module_ula_74181_seq16
    import pkg_ula_74181::*;
(
    input  logic                          clk,
    input  logic                          rst,
    module_ula_74181_seq16_if.slave       bus
);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             eq_acc_q, eq_acc_d;
    logic [WIDTH-1:0] a_cap_q, a_cap_d;
    logic [WIDTH-1:0] b_cap_q, b_cap_d;
    logic [3:0]       s_cap_q, s_cap_d;
    logic             m_cap_q, m_cap_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             c_out_q, c_out_d;
    logic             a_eq_b_q, a_eq_b_d;
    logic             zero_q, zero_d;

    logic [3:0] slice_a, slice_b, slice_f;
    logic       slice_c_out, slice_eq;
    logic       last_nibble;

    assign slice_a     = a_cap_q[{idx_q, 2'b00} +: 4];
    assign slice_b     = b_cap_q[{idx_q, 2'b00} +: 4];
    assign last_nibble = (idx_q == 2'(NIBBLES - 1));

    module_ula_74181 u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .s      (s_cap_q),
        .m      (m_cap_q),
        .c_in   (carry_q),
        .f      (slice_f),
        .c_out  (slice_c_out),
        .a_eq_b (slice_eq)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            carry_q  <= 1'b0;
            eq_acc_q <= 1'b0;
            a_cap_q  <= '0;
            b_cap_q  <= '0;
            s_cap_q  <= 4'h0;
            m_cap_q  <= 1'b0;
            result_q <= '0;
            f_q      <= '0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            eq_acc_q <= eq_acc_d;
            a_cap_q  <= a_cap_d;
            b_cap_q  <= b_cap_d;
            s_cap_q  <= s_cap_d;
            m_cap_q  <= m_cap_d;
            result_q <= result_d;
            f_q      <= f_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_nibble)   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Datapath next values. The visible outputs only change on the final
    // RUN edge, so they keep the previous result everywhere else.
    always_comb begin
        idx_d    = idx_q;
        carry_d  = carry_q;
        eq_acc_d = eq_acc_q;
        a_cap_d  = a_cap_q;
        b_cap_d  = b_cap_q;
        s_cap_d  = s_cap_q;
        m_cap_d  = m_cap_q;
        result_d = result_q;
        f_d      = f_q;
        c_out_d  = c_out_q;
        a_eq_b_d = a_eq_b_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_cap_d  = bus.a;
                    b_cap_d  = bus.b;
                    s_cap_d  = bus.s;
                    m_cap_d  = bus.m;
                    carry_d  = bus.c_in;
                    idx_d    = 2'd0;
                    eq_acc_d = 1'b1;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = slice_f;
                carry_d  = slice_c_out;
                eq_acc_d = eq_acc_q & slice_eq;
                idx_d    = idx_q + 2'd1;
                if (last_nibble) begin
                    f_d      = result_d;
                    c_out_d  = slice_c_out;
                    a_eq_b_d = eq_acc_q & slice_eq;
                    zero_d   = (result_d == '0);
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.f         = f_q;
        bus.c_out     = c_out_q;
        bus.a_eq_b    = a_eq_b_q;
        bus.zero      = zero_q;
    end

endmodule

// File: tb/tb_module_ula_74181_seq16.sv
// Self-checking bench for the nibble-serial 16-bit 74181 ALU.
module tb_module_ula_74181_seq16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [15:0] exp_f;
    logic        exp_c;
    logic        exp_eq;
    logic        exp_zero;

    module_ula_74181_seq16_if u_if ();

    module_ula_74181_seq16 dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Reference: the whole 16-bit word at once, straight from the
    // function table (arithmetic is X plus Y plus carry on 17 bits).
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] s, input logic m, input logic ci,
                                  output logic [15:0] f, output logic co);
        logic [15:0] x, y;
        logic [16:0] sum;
        x = 16'h0;
        y = 16'h0;
        if (m) begin
            case (s)
                4'd0:  f = ~a;
                4'd1:  f = ~(a | b);
                4'd2:  f = ~a & b;
                4'd3:  f = 16'h0000;
                4'd4:  f = ~(a & b);
                4'd5:  f = ~b;
                4'd6:  f = a ^ b;
                4'd7:  f = a & ~b;
                4'd8:  f = ~a | b;
                4'd9:  f = ~(a ^ b);
                4'd10: f = b;
                4'd11: f = a & b;
                4'd12: f = 16'hFFFF;
                4'd13: f = a | ~b;
                4'd14: f = a | b;
                default: f = a;
            endcase
            co = 1'b0;
        end else begin
            case (s)
                4'd0:  begin x = a;          y = 16'h0;   end // A
                4'd1:  begin x = a | b;      y = 16'h0;   end // A+B (or)
                4'd2:  begin x = a | ~b;     y = 16'h0;   end
                4'd3:  begin x = 16'hFFFF;   y = 16'h0;   end // minus 1
                4'd4:  begin x = a;          y = a & ~b;  end
                4'd5:  begin x = a | b;      y = a & ~b;  end
                4'd6:  begin x = a;          y = ~b;      end // A - B - 1
                4'd7:  begin x = a & ~b;     y = 16'hFFFF; end
                4'd8:  begin x = a;          y = a & b;   end
                4'd9:  begin x = a;          y = b;       end // A plus B
                4'd10: begin x = a | ~b;     y = a & b;   end
                4'd11: begin x = a & b;      y = 16'hFFFF; end
                4'd12: begin x = a;          y = a;       end // 2A
                4'd13: begin x = a | b;      y = a;       end
                4'd14: begin x = a | ~b;     y = a;       end
                default: begin x = a;        y = 16'hFFFF; end // A - 1
            endcase
            sum = {1'b0, x} + {1'b0, y} + {16'h0, ci};
            f  = sum[15:0];
            co = sum[16];
        end
    endfunction

    // Issue one operation and check the result when DONE is reached.
    // With scramble set, operands and in_valid churn during RUN.
    task automatic op_to_done(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] s, input logic m, input logic ci,
                              input bit scramble);
        model(a, b, s, m, ci, exp_f, exp_c);
        exp_eq   = (a == b);
        exp_zero = (exp_f == 16'h0);
        u_if.a = a; u_if.b = b; u_if.s = s; u_if.m = m; u_if.c_in = ci;
        u_if.in_valid = 1'b1;
        chk1({tag, ".in_ready_idle"}, u_if.in_ready, 1'b1);
        @(negedge clk);
        u_if.in_valid = 1'b0;
        chk1({tag, ".in_ready_run"}, u_if.in_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (scramble) begin
                u_if.a = 16'($urandom);
                u_if.b = 16'($urandom);
                u_if.s = 4'($urandom);
                u_if.m = 1'($urandom);
                u_if.c_in = 1'($urandom);
                u_if.in_valid = (k < 3);
            end
            if (k == 3) chk1({tag, ".out_valid_early"}, u_if.out_valid, 1'b0);
            @(negedge clk);
        end
        u_if.in_valid = 1'b0;
        chk1 ({tag, ".out_valid"}, u_if.out_valid, 1'b1);
        chk16({tag, ".f"},         u_if.f, exp_f);
        chk1 ({tag, ".c_out"},     u_if.c_out, exp_c);
        chk1 ({tag, ".zero"},      u_if.zero, exp_zero);
        chk1 ({tag, ".a_eq_b"},    u_if.a_eq_b, exp_eq);
        $display("op %s a=%h b=%h s=%h m=%b cin=%b -> f=%h c_out=%b zero=%b eq=%b",
                 tag, a, b, s, m, ci, u_if.f, u_if.c_out, u_if.zero, u_if.a_eq_b);
    endtask

    task automatic release_result(input string tag);
        u_if.out_ready = 1'b1;
        @(negedge clk);
        u_if.out_ready = 1'b0;
        chk1 ({tag, ".in_ready_after"},  u_if.in_ready, 1'b1);
        chk1 ({tag, ".out_valid_after"}, u_if.out_valid, 1'b0);
        chk16({tag, ".f_retained"},      u_if.f, exp_f);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic [15:0] held_f;
        u_if.in_valid = 1'b0; u_if.out_ready = 1'b0;
        u_if.a = 16'h0; u_if.b = 16'h0; u_if.s = 4'h0; u_if.m = 1'b0; u_if.c_in = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk1 ("rst.out_valid", u_if.out_valid, 1'b0);
        chk16("rst.f",         u_if.f, 16'h0);
        chk1 ("rst.zero",      u_if.zero, 1'b0);
        chk1 ("rst.c_out",     u_if.c_out, 1'b0);
        chk1 ("rst.a_eq_b",    u_if.a_eq_b, 1'b0);
        rst = 1'b0;
        chk1 ("rst.in_ready",  u_if.in_ready, 1'b1);

        // Directed arithmetic cases: carry ripple across nibbles and wrap
        op_to_done("add_ripple", 16'h0FFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
        chk16("add_ripple.f_const", u_if.f, 16'h1000);
        release_result("add_ripple");
        op_to_done("add_wrap", 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1'b0);
        chk1("add_wrap.c_out_const", u_if.c_out, 1'b1);
        chk1("add_wrap.zero_const",  u_if.zero, 1'b1);
        release_result("add_wrap");

        // Logic mode
        op_to_done("xor", 16'hA5A5, 16'h5A5A, 4'b0110, 1'b1, 1'b1, 1'b0);
        chk16("xor.f_const", u_if.f, 16'hFFFF);
        release_result("xor");
        op_to_done("eq_same", 16'h1234, 16'h1234, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk1("eq_same.a_eq_b_const", u_if.a_eq_b, 1'b1);
        release_result("eq_same");
        op_to_done("eq_diff", 16'h1234, 16'h1235, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk1("eq_diff.a_eq_b_const", u_if.a_eq_b, 1'b0);
        release_result("eq_diff");

        // Back-pressure in DONE: outputs hold, new requests ignored
        op_to_done("hold", 16'h1357, 16'h2468, 4'b1001, 1'b0, 1'b1, 1'b0);
        held_f = u_if.f;
        for (int k = 0; k < 5; k++) begin
            u_if.in_valid = 1'b1;
            u_if.a = 16'($urandom);
            u_if.b = 16'($urandom);
            @(negedge clk);
            chk1 ("hold.out_valid", u_if.out_valid, 1'b1);
            chk1 ("hold.in_ready",  u_if.in_ready, 1'b0);
            chk16("hold.f",         u_if.f, exp_f);
        end
        u_if.in_valid = 1'b0;
        chk16("hold.f_vs_first", u_if.f, held_f);
        release_result("hold");

        // Reset mid-RUN at nibble 2 abandons the operation
        u_if.a = 16'h4321; u_if.b = 16'h1111; u_if.s = 4'b1001; u_if.m = 1'b0; u_if.c_in = 1'b0;
        u_if.in_valid = 1'b1;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1 ("midrst.in_ready",  u_if.in_ready, 1'b1);
        chk1 ("midrst.out_valid", u_if.out_valid, 1'b0);
        chk16("midrst.f",         u_if.f, 16'h0);
        chk1 ("midrst.zero",      u_if.zero, 1'b0);
        op_to_done("after_rst", 16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b0, 1'b0);
        release_result("after_rst");

        // Inputs churning during RUN must not affect the captured operation
        op_to_done("scramble", 16'hBEEF, 16'h0123, 4'b0110, 1'b0, 1'b1, 1'b1);
        release_result("scramble");

        // Randomized operations across the whole function table
        for (int n = 0; n < 24; n++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
            op_to_done("rand", ra, rb, 4'($urandom), 1'($urandom), 1'($urandom),
                       1'($urandom));
            release_result("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/module_ula_74181_seq16.md
MODULE_ULA_74181_SEQ16 -- requirements
Module: module_ula_74181_seq16

Interface
REQ-001 SHALL have ports: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid  input  1  operation request.
REQ-004 SHALL have ports: in_ready  output  1  block can accept an operation.
REQ-005 SHALL have ports: a  input  16  operand A.
REQ-006 SHALL have ports: b  input  16  operand B.
REQ-007 SHALL have ports: s  input  4  function select, same encoding as the 4-bit 74181 slice.
REQ-008 SHALL have ports: m  input  1  mode; 1 = logic, 0 = arithmetic.
REQ-009 SHALL have ports: c_in  input  1  carry-in to nibble 0.
REQ-010 SHALL have ports: f  output  16  result.
REQ-011 SHALL have ports: c_out  output  1  carry-out of nibble 3.
REQ-012 SHALL have ports: a_eq_b  output  1  high when the captured A equals the captured B (all 16 bits).
REQ-013 SHALL have ports: zero  output  1  high when f == 16'h0000.
REQ-014 SHALL have ports: out_valid  output  1  result is valid.
REQ-015 SHALL have ports: out_ready  input  1  consumer accepts the result.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 SHALL capture a, b, s, m and c_in into internal registers on the edge where in_valid && in_ready; the next state SHALL be RUN, with nibble index 0 and carry register = c_in.
REQ-018 SHALL ignore input changes after capture; only the captured copies drive the computation.
REQ-019 In RUN, each cycle SHALL present captured nibble [4i+3:4i] of A and B, plus the captured s, m and the carry register, to the slice, where i is the nibble index.
REQ-020 On each RUN edge, the block SHALL write the slice f into result nibble i, load the slice c_out into the carry register, AND the slice a_eq_b into an equality accumulator, and increment i.
REQ-021 SHALL go RUN -> DONE on the edge where i == 3; the 2-bit index wraps to 0 and is not used in DONE.
REQ-022 Latency SHALL be exactly 4 edges from the accept edge to out_valid high, i.e. the accept edge plus 4 RUN edges.
REQ-023 In DONE, f, c_out, a_eq_b and zero SHALL hold stable until the edge where out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-024 in_valid in any state other than IDLE SHALL be ignored, with no capture; minimum issue interval is 6 cycles.
REQ-025 In logic mode (m = 1), the chained carry SHALL be whatever the slice produces, which is 0; c_out is therefore 0.
REQ-026 The zero output SHALL be derived from the registered f; outputs outside DONE SHALL retain the last result.

Reset
REQ-027 When rst is high at an edge, the block SHALL enter IDLE, clear f, c_out, a_eq_b, zero, out_valid, the carry register, the nibble index and the accumulator to 0 (zero output = 0), and load the equality accumulator to 1 at the next capture.
REQ-028 rst SHALL take priority over every other input, including a mid-RUN or DONE operation, which is abandoned with no output produced.
REQ-029 in_ready SHALL be 1 on the first cycle after reset deasserts.

Structure
REQ-030 Package pkg_ula_74181 SHALL hold: WIDTH = 16, NIBBLES = 4, and the state enum (IDLE, RUN, DONE).
REQ-031 SHALL instantiate exactly one module_ula_74181 as the time-multiplexed 4-bit slice; no other sub-modules.

Verification
REQ-032 Bench SHALL check: m=0, s=1001, a=16'h0FFF, b=16'h0001, c_in=0 -> after 4 edges, f=16'h1000, c_out=0, zero=0, a_eq_b=0.
REQ-033 Bench SHALL check: m=0, s=1001, a=16'hFFFF, b=16'h0001, c_in=0 -> f=16'h0000, c_out=1, zero=1.
REQ-034 Bench SHALL check: m=1, s=0110, a=16'hA5A5, b=16'h5A5A -> f=16'hFFFF, c_out=0; a=b=16'h1234 gives a_eq_b=1, and b=16'h1235 gives a_eq_b=0.
REQ-035 Bench SHALL check: out_ready held 0 for 5 cycles in DONE -> outputs stable and in_valid ignored; out_ready=1 -> IDLE next edge, with in_ready=1.
REQ-036 Bench SHALL check: rst pulsed during RUN at nibble 2 -> next cycle IDLE, out_valid=0, f=0; a new operation then completes with the correct result.
REQ-037 Bench SHALL check: a and b changed every cycle during RUN -> result matches the values captured at the accept edge.
